// File: rtl/pdpu_pkg.sv
// Shared state encoding and elaboration helpers for the PDPU stream controller.
package pdpu_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pdpu_lane_buf.sv
// N-lane operand buffer: one (a, b) element pair per lane, indexed write, synchronous clear.
module pdpu_lane_buf
  import pdpu_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int IDX_W = (N > 1) ? clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic [N*W-1:0]   a_o,
  output logic [N*W-1:0]   b_o
);

  logic [N*W-1:0] a_q;
  logic [N*W-1:0] b_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      a_q <= '0;
      b_q <= '0;
    end else if (wr_i) begin
      for (int i = 0; i < N; i++) begin
        if (idx_i == IDX_W'(i)) begin
          a_q[i*W +: W] <= a_i;
          b_q[i*W +: W] <= b_i;
        end
      end
    end
  end

  assign a_o = a_q;
  assign b_o = b_q;

endmodule

// File: rtl/pdpu_stream_ctrl.sv
// Streams posit element pairs into N-lane chunks for an external pdpu_top and
// accumulates its result until the element tagged last, then presents the dot product.
//
//   state | meaning
//   FILL  | accepting element pairs into lanes
//   ISSUE | lanes/acc presented to pdpu; capture here when pdpu is combinational
//   WAIT  | holding pdpu inputs while the latency counter runs down
//   DONE  | final result valid, waiting for the consumer
module pdpu_stream_ctrl
  import pdpu_pkg::*;
#(
  parameter int N        = 4,
  parameter int n_i      = 8,
  parameter int es_i     = 2,
  parameter int n_o      = 16,
  parameter int es_o     = 2,
  parameter int PDPU_LAT = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [n_i-1:0]   in_a_i,
  input  logic [n_i-1:0]   in_b_i,
  input  logic             in_last_i,
  output logic [N*n_i-1:0] pdpu_a_o,
  output logic [N*n_i-1:0] pdpu_b_o,
  output logic [n_o-1:0]   pdpu_acc_o,
  input  logic [n_o-1:0]   pdpu_result_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [n_o-1:0]   out_result_o
);

  localparam int CNT_W = (N > 1) ? clog2(N) : 1;

  if (es_i >= n_i || es_o >= n_o) begin : g_cfg_err
    $error("pdpu_stream_ctrl: exponent size must be smaller than word size");
  end

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;
  logic [n_o-1:0]   acc_q;
  logic             hs_in;
  logic             out_ack;
  logic             capture;
  logic             lat_zero;

  assign in_ready_o  = (state_q == FILL);
  assign out_valid_o = (state_q == DONE);
  assign hs_in       = in_valid_i && in_ready_o;
  assign out_ack     = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      FILL:    if (hs_in && (cnt_q == CNT_W'(N - 1) || in_last_i)) state_d = ISSUE;
      ISSUE:   if (PDPU_LAT == 0) capture = 1'b1;
               else               state_d = WAIT;
      WAIT:    if (lat_zero) capture = 1'b1;
      DONE:    if (out_ready_i) state_d = FILL;
      default: state_d = FILL;
    endcase
    if (capture) state_d = last_q ? DONE : FILL;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= FILL;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (hs_in) begin
        cnt_q  <= cnt_q + 1'b1;
        last_q <= in_last_i;
      end
      if (capture) begin
        cnt_q <= '0;
        acc_q <= pdpu_result_i;
      end
      if (out_ack) begin
        acc_q  <= '0;
        last_q <= 1'b0;
      end
    end
  end

  // Counter loads on the ISSUE cycle so capture lands PDPU_LAT cycles after issue.
  if (PDPU_LAT > 0) begin : g_lat
    localparam int LAT_W = (clog2(PDPU_LAT + 1) > 0) ? clog2(PDPU_LAT + 1) : 1;
    logic [LAT_W-1:0] lat_q;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        lat_q <= '0;
      end else if (state_q == ISSUE) begin
        lat_q <= LAT_W'(PDPU_LAT - 1);
      end else if (state_q == WAIT && lat_q != '0) begin
        lat_q <= lat_q - 1'b1;
      end
    end

    assign lat_zero = (lat_q == '0);
  end else begin : g_no_lat
    assign lat_zero = 1'b1;
  end

  pdpu_lane_buf #(
    .N     (N),
    .W     (n_i),
    .IDX_W (CNT_W)
  ) u_lane_buf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (capture),
    .wr_i   (hs_in),
    .idx_i  (cnt_q),
    .a_i    (in_a_i),
    .b_i    (in_b_i),
    .a_o    (pdpu_a_o),
    .b_o    (pdpu_b_o)
  );

  assign pdpu_acc_o   = acc_q;
  assign out_result_o = out_valid_o ? acc_q : '0;

endmodule
